user_in_fifo: RTL and testbench

Elastic input buffer on the user-kernel side of a leaf. It sits between one `dout_leaf_interface2user_N / vld_interface2user_N / ack_user2interface_N` port of `leaf_interface` and the HLS user kernel, in the `clk_user` domain. It decouples kernel stalls from the interface and presents first-word-fall-through (FWFT) data with a registered output. It also keeps occupancy and a transfer counter for debug readback.

---
 rtl/user_in_fifo_if.sv | 49 ++++
 rtl/user_in_fifo.sv | 146 ++++++++++++++
 tb/tb_user_in_fifo.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_in_fifo_if.sv
// ---------------------------------------------------------------------------
// user_in_fifo_if
//
// Stream bundle between leaf_interface, user_in_fifo and the HLS user kernel.
// The signal names match the buffer's own port list.
//
//   din      interface -> buffer   upstream data
//   vld_in   interface -> buffer   din valid
//   ack_out  buffer -> interface   upstream acceptance
//   dout     buffer -> kernel      downstream data (registered)
//   vld_out  buffer -> kernel      dout valid (registered)
//   ack_in   kernel -> buffer      kernel consumes dout
//
// Handshake: a beat moves on a rising clock edge where valid and ack are both
// high. The sender holds data/valid stable until it sees ack. Ack never
// depends combinationally on the other side's valid or ack.
//
// Modports:
//   master - the environment around the buffer (interface + kernel side)
//   slave  - the buffer itself
// ---------------------------------------------------------------------------
interface user_in_fifo_if #(
    parameter int PAYLOAD_BITS = 32
);
    logic [PAYLOAD_BITS-1:0] din;
    logic                    vld_in;
    logic                    ack_out;
    logic [PAYLOAD_BITS-1:0] dout;
    logic                    vld_out;
    logic                    ack_in;

    modport master (
        output din,
        output vld_in,
        output ack_in,
        input  ack_out,
        input  dout,
        input  vld_out
    );

    modport slave (
        input  din,
        input  vld_in,
        input  ack_in,
        output ack_out,
        output dout,
        output vld_out
    );
endinterface

// File: rtl/user_in_fifo.sv
// ---------------------------------------------------------------------------
// user_in_fifo
//
// Elastic input buffer between a leaf_interface user port and the HLS user
// kernel, in the clk_user domain. It presents first-word-fall-through data
// from a registered output stage and decouples kernel stalls from the
// interface.
//
// Ports:
//   clk_user  in   user clock (rising edge only)
//   reset     in   asynchronous, active-high reset
//   bus       slave modport of user_in_fifo_if (din/vld_in/ack_out upstream,
//             dout/vld_out/ack_in downstream)
//   count     out  words held, output register included (0..DEPTH)
//   full      out  count == DEPTH
//   empty     out  count == 0
//   xfer_cnt  out  words delivered to the kernel since reset (wraps)
//
// Storage is a circular RAM plus the output register. The output register
// counts as one of the DEPTH entries, so total capacity is exactly DEPTH.
// The RAM can therefore never hold more than DEPTH-1 words, and wr_ptr never
// catches rd_ptr while the RAM still holds data.
// ---------------------------------------------------------------------------
module user_in_fifo #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4,
    parameter int CNT_BITS     = 32
) (
    input  logic                  clk_user,
    input  logic                  reset,
    user_in_fifo_if.slave         bus,
    output logic [DEPTH_BITS:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_BITS-1:0]   xfer_cnt
);
    localparam int                  DEPTH     = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);

    // Storage
    logic [PAYLOAD_BITS-1:0] mem [DEPTH];

    // State registers
    logic [DEPTH_BITS-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [DEPTH_BITS-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [DEPTH_BITS:0]     count_q,   count_d;
    logic                    out_vld_q, out_vld_d;
    logic [PAYLOAD_BITS-1:0] dout_q,    dout_d;
    logic                    ack_q,     ack_d;
    logic [CNT_BITS-1:0]     xfer_q,    xfer_d;

    // Per-cycle decode
    logic                    wr;
    logic                    rd;
    logic                    load;
    logic                    ram_empty;
    logic                    bypass;
    logic                    ram_we;
    logic [DEPTH_BITS:0]     ram_cnt;

    always_comb begin
        // The RAM holds everything except the word sitting in the output stage.
        ram_cnt   = count_q - {{DEPTH_BITS{1'b0}}, out_vld_q};
        ram_empty = (ram_cnt == '0);

        // ack_q is low while full and throughout reset, so no write can land
        // during reset and vld_in is simply held off when full.
        wr   = bus.vld_in & ack_q;
        rd   = out_vld_q & bus.ack_in;
        // The output stage refills when it is empty or being drained now.
        load = ~out_vld_q | rd;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        out_vld_d = out_vld_q;
        dout_d    = dout_q;
        bypass    = 1'b0;

        if (load) begin
            if (!ram_empty) begin
                // Oldest word is at the RAM head; it must go out before din.
                dout_d    = mem[rd_ptr_q];
                rd_ptr_d  = rd_ptr_q + 1'b1;
                out_vld_d = 1'b1;
            end else if (wr) begin
                // Nothing queued: din goes straight to the output stage,
                // giving one-edge latency into an empty buffer.
                dout_d    = bus.din;
                out_vld_d = 1'b1;
                bypass    = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end

        ram_we = wr & ~bypass;
        if (ram_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        count_d = count_q + {{DEPTH_BITS{1'b0}}, wr} - {{DEPTH_BITS{1'b0}}, rd};

        // Acceptance is registered from the next occupancy, so it never sees
        // ack_in combinationally and rises one edge after reset release.
        ack_d  = (count_d != DEPTH_CNT);

        xfer_d = xfer_q + {{(CNT_BITS-1){1'b0}}, rd};
    end

    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
            dout_q    <= '0;
            ack_q     <= 1'b0;
            xfer_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
            dout_q    <= dout_d;
            ack_q     <= ack_d;
            xfer_q    <= xfer_d;
        end
    end

    // RAM contents need no reset: occupancy and pointers define validity.
    always_ff @(posedge clk_user) begin
        if (ram_we) begin
            mem[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.ack_out = ack_q;
    assign bus.vld_out = out_vld_q;
    assign bus.dout    = dout_q;

    assign count    = count_q;
    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign xfer_cnt = xfer_q;

endmodule

// File: tb/tb_user_in_fifo.sv
module tb_user_in_fifo;
    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic          clk_user = 1'b0;
    logic          reset;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic [31:0]   xfer_cnt;

    always #5 clk_user = ~clk_user;

    user_in_fifo_if #(.PAYLOAD_BITS(W)) bus ();

    user_in_fifo #(
        .PAYLOAD_BITS(W),
        .DEPTH_BITS  (4),
        .CNT_BITS    (32)
    ) dut (
        .clk_user (clk_user),
        .reset    (reset),
        .bus      (bus.slave),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .xfer_cnt (xfer_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_reads  = 0;
    int           max_count = 0;
    logic [W-1:0] last_rd;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset      = 1'b1;
        bus.vld_in = 1'b0;
        bus.ack_in = 1'b0;
        bus.din    = '0;
        exp_q.delete();
        repeat (2) @(posedge clk_user);
        @(negedge clk_user);
        reset = 1'b0;
        @(posedge clk_user);
        #1;
    endtask

    // One clock: drive at negedge, decide handshakes from the registered
    // outputs, score any read against the expected queue, then step the edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic a,
                         output logic wr, output logic rd);
        logic [W-1:0] exp;
        @(negedge clk_user);
        bus.vld_in = v;
        bus.din    = d;
        bus.ack_in = a;
        #1;
        wr = bus.vld_in && bus.ack_out;
        rd = bus.vld_out && bus.ack_in;
        if (rd) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_underflow: dout=%h read with nothing expected", bus.dout);
            end else begin
                exp = exp_q.pop_front();
                if (bus.dout !== exp)
                    $display("FAIL sb_order: dout=%h expected=%h", bus.dout, exp);
                else
                    n_pass++;
            end
            last_rd = bus.dout;
            n_reads++;
        end
        if (wr) exp_q.push_back(d);
        @(posedge clk_user);
        #1;
        if (int'(count) > max_count) max_count = int'(count);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset      = 1'b1;
        bus.vld_in = 1'b1;
        bus.ack_in = 1'b1;
        bus.din    = 32'h1234_5678;
        repeat (2) @(posedge clk_user);
        #1;
        n_checks++; if (bus.ack_out !== 1'b0) $display("FAIL rst_ack_out: got %b want 0", bus.ack_out); else n_pass++;
        n_checks++; if (bus.vld_out !== 1'b0) $display("FAIL rst_vld_out: got %b want 0", bus.vld_out); else n_pass++;
        n_checks++; if (bus.dout !== 32'h0) $display("FAIL rst_dout: got %h want 0", bus.dout); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL rst_full: got %b want 0", full); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (xfer_cnt !== 32'd0) $display("FAIL rst_xfer: got %0d want 0", xfer_cnt); else n_pass++;
        bus.vld_in = 1'b0;
        bus.ack_in = 1'b0;
        @(negedge clk_user);
        reset = 1'b0;
        #1;
        n_checks++; if (bus.ack_out !== 1'b0) $display("FAIL rel_ack_before_edge: got %b want 0", bus.ack_out); else n_pass++;
        @(posedge clk_user);
        #1;
        n_checks++; if (bus.ack_out !== 1'b1) $display("FAIL rel_ack_after_edge: got %b want 1", bus.ack_out); else n_pass++;
    endtask

    task automatic test_single();
        logic wr, rd;
        do_reset();
        cycle(1'b1, 32'hA5A5_0001, 1'b1, wr, rd);
        n_checks++; if (wr !== 1'b1) $display("FAIL single_wr: got %b want 1", wr); else n_pass++;
        n_checks++; if (bus.vld_out !== 1'b1) $display("FAIL single_vld: got %b want 1", bus.vld_out); else n_pass++;
        n_checks++; if (bus.dout !== 32'hA5A5_0001) $display("FAIL single_dout: got %h want a5a50001", bus.dout); else n_pass++;
        n_checks++; if (count !== 5'd1) $display("FAIL single_count: got %0d want 1", count); else n_pass++;
        cycle(1'b0, '0, 1'b1, wr, rd);
        n_checks++; if (rd !== 1'b1) $display("FAIL single_rd: got %b want 1", rd); else n_pass++;
        n_checks++; if (xfer_cnt !== 32'd1) $display("FAIL single_xfer: got %0d want 1", xfer_cnt); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL single_empty: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_fill_drain();
        logic wr, rd;
        int   word, acc, guard, reads0;
        do_reset();
        word = 1; acc = 0;
        for (int c = 0; c < 24; c++) begin
            cycle(1'b1, W'(word), 1'b0, wr, rd);
            if (wr) begin
                word++;
                acc++;
            end
        end
        n_checks++; if (acc != 16) $display("FAIL fill_accepted: got %0d want 16", acc); else n_pass++;
        n_checks++; if (bus.ack_out !== 1'b0) $display("FAIL fill_ack_out: got %b want 0", bus.ack_out); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else n_pass++;
        n_checks++; if (count !== 5'd16) $display("FAIL fill_count: got %0d want 16", count); else n_pass++;
        n_checks++; if (bus.dout !== 32'd1) $display("FAIL fill_head: got %h want 1", bus.dout); else n_pass++;
        reads0 = n_reads;
        guard  = 0;
        while ((word <= 20 || exp_q.size() > 0) && guard < 100) begin
            cycle(word <= 20, W'(word), 1'b1, wr, rd);
            if (wr) word++;
            guard++;
        end
        n_checks++; if (guard >= 100) $display("FAIL drain_timeout: cycles=%0d limit=100", guard); else n_pass++;
        n_checks++; if (n_reads - reads0 != 20) $display("FAIL drain_reads: got %0d want 20", n_reads - reads0); else n_pass++;
        n_checks++; if (last_rd !== 32'd20) $display("FAIL drain_last: got %h want 14", last_rd); else n_pass++;
        n_checks++; if (xfer_cnt !== 32'd20) $display("FAIL drain_xfer: got %0d want 20", xfer_cnt); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_full_rw();
        logic wr, rd;
        int   guard;
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, W'(32'h100 + i), 1'b0, wr, rd);
        n_checks++; if (full !== 1'b1) $display("FAIL frw_full: got %b want 1", full); else n_pass++;
        cycle(1'b1, 32'h999, 1'b1, wr, rd);
        n_checks++; if (wr !== 1'b0) $display("FAIL frw_no_write: got %b want 0", wr); else n_pass++;
        n_checks++; if (rd !== 1'b1) $display("FAIL frw_read: got %b want 1", rd); else n_pass++;
        n_checks++; if (count !== 5'd15) $display("FAIL frw_count: got %0d want 15", count); else n_pass++;
        n_checks++; if (bus.ack_out !== 1'b1) $display("FAIL frw_ack_next: got %b want 1", bus.ack_out); else n_pass++;
        n_checks++; if (bus.dout !== 32'h101) $display("FAIL frw_next_head: got %h want 101", bus.dout); else n_pass++;
        guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            cycle(1'b0, '0, 1'b1, wr, rd);
            guard++;
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL frw_empty: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_random();
        logic         wr, rd;
        logic [W-1:0] word;
        int           sent, reads0, guard;
        do_reset();
        max_count = 0;
        reads0 = n_reads;
        sent   = 0;
        guard  = 0;
        word   = $urandom;
        while ((n_reads - reads0) < 1000 && guard < 20000) begin
            cycle((sent < 1000) && ($urandom_range(0, 1) == 1), word,
                  ($urandom_range(0, 1) == 1), wr, rd);
            if (wr) begin
                sent++;
                word = $urandom;
            end
            guard++;
        end
        n_checks++; if (n_reads - reads0 != 1000) $display("FAIL rand_reads: got %0d want 1000", n_reads - reads0); else n_pass++;
        n_checks++; if (max_count > 16) $display("FAIL rand_max_count: got %0d limit 16", max_count); else n_pass++;
        n_checks++; if (xfer_cnt !== 32'd1000) $display("FAIL rand_xfer: got %0d want 1000", xfer_cnt); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL rand_leftover: got %0d want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic wr, rd;
        int   reads0;
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, W'(32'h200 + i), 1'b0, wr, rd);
        n_checks++; if (count !== 5'd10) $display("FAIL mid_count_before: got %0d want 10", count); else n_pass++;
        @(negedge clk_user);
        #2;
        reset      = 1'b1;
        bus.vld_in = 1'b0;
        #1;
        n_checks++; if (bus.vld_out !== 1'b0) $display("FAIL mid_vld_out: got %b want 0", bus.vld_out); else n_pass++;
        n_checks++; if (bus.dout !== 32'h0) $display("FAIL mid_dout: got %h want 0", bus.dout); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL mid_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL mid_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (bus.ack_out !== 1'b0) $display("FAIL mid_ack_out: got %b want 0", bus.ack_out); else n_pass++;
        exp_q.delete();
        @(posedge clk_user);
        @(negedge clk_user);
        reset = 1'b0;
        @(posedge clk_user);
        #1;
        reads0 = n_reads;
        cycle(1'b1, 32'h0000_BEEF, 1'b1, wr, rd);
        cycle(1'b0, '0, 1'b1, wr, rd);
        n_checks++; if (n_reads - reads0 != 1) $display("FAIL mid_reads: got %0d want 1", n_reads - reads0); else n_pass++;
        n_checks++; if (last_rd !== 32'h0000_BEEF) $display("FAIL mid_first_dout: got %h want 0000beef", last_rd); else n_pass++;
    endtask

    task automatic test_wrap();
        logic wr, rd;
        int   guard, acc;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            acc   = 0;
            guard = 0;
            while (acc < 13 && guard < 30) begin
                cycle(1'b1, W'(32'h3000 + p * 16 + acc), 1'b0, wr, rd);
                if (wr) acc++;
                guard++;
            end
            n_checks++; if (count !== 5'd13) $display("FAIL wrap_fill%0d: got %0d want 13", p, count); else n_pass++;
            guard = 0;
            while (exp_q.size() > 0 && guard < 40) begin
                cycle(1'b0, '0, 1'b1, wr, rd);
                guard++;
            end
            n_checks++; if (empty !== 1'b1) $display("FAIL wrap_empty%0d: got %b want 1", p, empty); else n_pass++;
        end
        n_checks++; if (xfer_cnt !== 32'd39) $display("FAIL wrap_xfer: got %0d want 39", xfer_cnt); else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset      = 1'b1;
        bus.vld_in = 1'b0;
        bus.ack_in = 1'b0;
        bus.din    = '0;
        last_rd    = '0;
        test_reset();
        test_single();
        test_fill_drain();
        test_full_rw();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
